ysyx_22050598_csr_unit: RTL
===========================

Name: ysyx_22050598_csr_unit

Overview:
Parametrised machine-mode CSR file and trap controller for the EXU. It generalises the earlier CSR block:
- configurable XLEN;
- mstatus MIE/MPIE stacking on trap entry and mret;
- mie/mip/mscratch registers;
- a machine-timer interrupt path with vectored mtvec;
- 64-bit cycle/instret counters.

It sits beside the ALU and produces a CSR read value plus a PC redirect to the IFU.

Parameters:
XLEN, 64, CSR/data width (32 or 64)
MSTATUS_RESETVAL, 'h1800, mstatus reset value (MPP=2'b11)
MTVEC_RESETVAL, 0, mtvec reset value

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset
valid_i  in  1  EXU holds a valid instruction this cycle
csr_op_i  in  6  one-hot: [5]csrrw [4]csrrs [3]csrrc [2]csrrwi [1]csrrsi [0]csrrci
csr_addr_i  in  12  CSR address
csr_rs1_i  in  XLEN  rs1 operand
csr_zimm_i  in  5  zimm, zero-extended internally
ecall_i  in  1  instruction is ecall
mret_i  in  1  instruction is mret
pc_i  in  XLEN  PC of the EXU instruction
timer_irq_i  in  1  level machine-timer interrupt request
csr_rdata_o  out  XLEN  old CSR value, for rd write-back
illegal_csr_o  out  1  CSR op targets an unimplemented address
redirect_o  out  1  PC redirect this cycle
redirect_pc_o  out  XLEN  redirect target

Behaviour:
Implemented CSRs:
- mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored. MPP reads 2'b11. All other bits read 0.
- mie 0x304: only MTIE[7] is stored.
- mtvec 0x305: stores BASE[XLEN-1:2] and MODE[1:0]. MODE values 2 and 3 are written as 0.
- mscratch 0x340: full width.
- mepc 0x341: bits [1:0] are forced to 0 on every write.
- mcause 0x342: full width.
- mip 0x344: read-only. MTIP[7] = timer_irq_i registered once (1-cycle latency). Writes are silently dropped and do not raise illegal_csr_o.

Reset (rst=0 at an edge):
- mstatus=MSTATUS_RESETVAL, mtvec=MTVEC_RESETVAL, every other CSR and counter = 0.
- Outputs: redirect_o=0, illegal_csr_o=0, csr_rdata_o=0.
- Reset asserted mid-operation discards any pending trap or write.

CSR access (all gated by valid_i):
- Reads are combinational. csr_rdata_o returns the pre-edge value.
- Write value: rw = src; rs = old|src; rc = old&~src. src = csr_rs1_i for bits 5..3 and zext(zimm) for bits 2..0.
- The write commits at the next edge.
- rs/rc with src=0 performs no write, and has no side effects on counters.
- Unimplemented address: csr_rdata_o=0, no state change, illegal_csr_o=1 combinationally.

Event priority within one valid cycle, highest first: interrupt > ecall > mret > CSR op. A lower-priority action in the same cycle is suppressed.

Interrupt condition: valid_i & mstatus.MIE & mie.MTIE & mip.MTIP.
- The instruction is not executed.
- mepc<=pc_i, mcause<={1'b1, 7}, MPIE<=MIE, MIE<=0.
- redirect_pc_o = BASE if MODE=0, else BASE+28.

ecall:
- mepc<=pc_i, mcause<=11, MPIE<=MIE, MIE<=0.
- redirect_pc_o = BASE (synchronous traps never vector).

mret: MIE<=MPIE, MPIE<=1, redirect_pc_o=mepc (pre-edge value).

redirect_o is combinational in the same cycle as the triggering valid_i and deasserts the next cycle unless a new event occurs.

A CSR write to mstatus in the same cycle as a trap is suppressed; the trap's stacking wins.

Optional Feature:
Macro ysyx_22050598_CSR_COUNTERS_EN.

When defined:
- mcycle 0xB00 increments every cycle out of reset.
- minstret 0xB02 increments on valid_i when no interrupt is taken.
- Both are 64-bit and wrap from all-ones to 0.
- At XLEN=32, 0xB80/0xB82 read and write the upper halves.
- A CSR write to a counter in the same cycle overrides that cycle's increment; the written value is visible next cycle with no increment applied.
- Read-only aliases cycle 0xC00 and instret 0xC02 read the same values. Writes to the aliases set illegal_csr_o.

When undefined: all counter addresses are unimplemented (read 0, illegal_csr_o=1).

Test Plan:
1. csrrw mtvec,x1 (x1=0x8000_0100); next cycle csrrs x2,mtvec,x0 -> x2 read 0x8000_0100, no write, illegal_csr_o=0.
2. mstatus.MIE=1, ecall at pc=0x8000_0040 -> redirect_o=1, pc=0x8000_0100; next cycle mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1. mret then -> redirect to 0x8000_0040, MIE=1, MPIE=1.
3. mtvec=0x8000_0101 (vectored), MIE=1, MTIE=1, timer_irq_i raised -> the second valid cycle after the raise redirects to 0x8000_011C. mcause=0x8000_0000_0000_0007, and the trapped instruction does not retire.
4. Same cycle: interrupt pending and ecall -> interrupt taken, mcause interrupt bit set, ecall suppressed.
5. csrrw to address 0x7C0 -> illegal_csr_o=1, rdata=0, no CSR changes. csrrw mip -> MTIP unchanged, illegal_csr_o=0.
6. With counters enabled: csrrw mcycle to 0xFFFF_FFFF_FFFF_FFFE -> reads 0xFFFF_FFFF_FFFF_FFFE next cycle, then wraps to 0 two cycles later. Reset mid-run -> mcycle=0, minstret=0.

Source files
------------

// File: rtl/ysyx_22050598_csr_unit_if.sv
// EXU <-> CSR unit bus: instruction-side request fields and the CSR
// read-back / PC-redirect response. The EXU drives the master side and
// the CSR unit sits on the slave side.
interface ysyx_22050598_csr_unit_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic [5:0]      csr_op_i;
    logic [11:0]     csr_addr_i;
    logic [XLEN-1:0] csr_rs1_i;
    logic [4:0]      csr_zimm_i;
    logic            ecall_i;
    logic            mret_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic            illegal_csr_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output valid_i, csr_op_i, csr_addr_i, csr_rs1_i, csr_zimm_i,
        output ecall_i, mret_i, pc_i,
        input  csr_rdata_o, illegal_csr_o, redirect_o, redirect_pc_o
    );

    modport slave (
        input  valid_i, csr_op_i, csr_addr_i, csr_rs1_i, csr_zimm_i,
        input  ecall_i, mret_i, pc_i,
        output csr_rdata_o, illegal_csr_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/ysyx_22050598_csr_unit.sv
// Machine-mode CSR file and trap controller beside the EXU.
// Holds mstatus/mie/mtvec/mscratch/mepc/mcause/mip, takes the machine-timer
// interrupt, ecall and mret, and steers the IFU through redirect_o.
// Optional 64-bit mcycle/minstret counters are built when the macro
// ysyx_22050598_CSR_COUNTERS_EN is defined; otherwise their addresses are
// unimplemented.
module ysyx_22050598_csr_unit #(
    parameter int              XLEN             = 64,
    parameter logic [XLEN-1:0] MSTATUS_RESETVAL = XLEN'('h1800),
    parameter logic [XLEN-1:0] MTVEC_RESETVAL   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   timer_irq_i,
    ysyx_22050598_csr_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
`ifdef ysyx_22050598_CSR_COUNTERS_EN
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
`endif
    localparam logic [XLEN-1:0] IRQ_CAUSE   = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);
    localparam logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11);

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic            mtie_q, mtie_d, mtip_q, mtip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
`ifdef ysyx_22050598_CSR_COUNTERS_EN
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
`endif

    logic            irq_take, ecall_take, mret_take, csr_exec;
    logic            addr_ok, is_mip, is_alias, wr_en, commit, illegal;
    logic [XLEN-1:0] rd_val, src, wr_val, trap_base;

    // Event arbitration: interrupt beats ecall beats mret beats the CSR op.
    always_comb begin
        irq_take   = rst & bus.valid_i & mie_q & mtie_q & mtip_q;
        ecall_take = rst & bus.valid_i & bus.ecall_i & ~irq_take;
        mret_take  = rst & bus.valid_i & bus.mret_i & ~irq_take & ~bus.ecall_i;
        csr_exec   = rst & bus.valid_i & (|bus.csr_op_i) & ~irq_take
                   & ~bus.ecall_i & ~bus.mret_i;
        trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
    end

    // Combinational CSR read mux; also classifies the addressed CSR.
    always_comb begin
        rd_val   = '0;
        addr_ok  = 1'b1;
        is_mip   = 1'b0;
        is_alias = 1'b0;
        case (bus.csr_addr_i)
            ADDR_MSTATUS: begin
                rd_val[3]     = mie_q;
                rd_val[7]     = mpie_q;
                rd_val[12:11] = 2'b11;
            end
            ADDR_MIE:      rd_val[7] = mtie_q;
            ADDR_MTVEC:    rd_val = mtvec_q;
            ADDR_MSCRATCH: rd_val = mscratch_q;
            ADDR_MEPC:     rd_val = mepc_q;
            ADDR_MCAUSE:   rd_val = mcause_q;
            ADDR_MIP: begin
                rd_val[7] = mtip_q;
                is_mip    = 1'b1;
            end
`ifdef ysyx_22050598_CSR_COUNTERS_EN
            ADDR_MCYCLE:   rd_val = XLEN'(mcycle_q);
            ADDR_MINSTRET: rd_val = XLEN'(minstret_q);
            ADDR_CYCLE: begin
                rd_val   = XLEN'(mcycle_q);
                is_alias = 1'b1;
            end
            ADDR_INSTRET: begin
                rd_val   = XLEN'(minstret_q);
                is_alias = 1'b1;
            end
            ADDR_MCYCLEH: begin
                if (XLEN == 32) rd_val = XLEN'(mcycle_q[63:32]);
                else            addr_ok = 1'b0;
            end
            ADDR_MINSTRETH: begin
                if (XLEN == 32) rd_val = XLEN'(minstret_q[63:32]);
                else            addr_ok = 1'b0;
            end
`endif
            default: addr_ok = 1'b0;
        endcase
    end

    // Read-modify-write value and whether the op really writes (rs/rc with a zero source do not).
    always_comb begin
        src    = (|bus.csr_op_i[5:3]) ? bus.csr_rs1_i : XLEN'(bus.csr_zimm_i);
        wr_en  = 1'b0;
        wr_val = rd_val;
        if (bus.csr_op_i[5] | bus.csr_op_i[2]) begin
            wr_en  = 1'b1;
            wr_val = src;
        end else if (bus.csr_op_i[4] | bus.csr_op_i[1]) begin
            wr_en  = |src;
            wr_val = rd_val | src;
        end else if (bus.csr_op_i[3] | bus.csr_op_i[0]) begin
            wr_en  = |src;
            wr_val = rd_val & ~src;
        end
        illegal = csr_exec & (~addr_ok | (is_alias & wr_en));
        commit  = csr_exec & wr_en & addr_ok & ~is_alias & ~is_mip;
    end

    // Next architectural state: trap stacking, mret unstacking, or the CSR write.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtie_d     = mtie_q;
        mtip_d     = timer_irq_i;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (irq_take | ecall_take) begin
            mepc_d   = bus.pc_i & ~XLEN'(3);
            mcause_d = irq_take ? IRQ_CAUSE : ECALL_CAUSE;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_take) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (commit) begin
            case (bus.csr_addr_i)
                ADDR_MSTATUS: begin
                    mie_d  = wr_val[3];
                    mpie_d = wr_val[7];
                end
                ADDR_MIE:      mtie_d = wr_val[7];
                ADDR_MTVEC:    mtvec_d = {wr_val[XLEN-1:2], wr_val[1] ? 2'b00 : wr_val[1:0]};
                ADDR_MSCRATCH: mscratch_d = wr_val;
                ADDR_MEPC:     mepc_d = wr_val & ~XLEN'(3);
                ADDR_MCAUSE:   mcause_d = wr_val;
                default: ;
            endcase
        end
    end

`ifdef ysyx_22050598_CSR_COUNTERS_EN
    // Free-running counters; a same-cycle CSR write replaces the increment.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.valid_i & ~irq_take};
        if (commit) begin
            case (bus.csr_addr_i)
                ADDR_MCYCLE: begin
                    if (XLEN == 32) mcycle_d = {mcycle_q[63:32], wr_val[31:0]};
                    else            mcycle_d = 64'(wr_val);
                end
                ADDR_MINSTRET: begin
                    if (XLEN == 32) minstret_d = {minstret_q[63:32], wr_val[31:0]};
                    else            minstret_d = 64'(wr_val);
                end
                ADDR_MCYCLEH:   mcycle_d   = {wr_val[31:0], mcycle_q[31:0]};
                ADDR_MINSTRETH: minstret_d = {wr_val[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_q      <= MSTATUS_RESETVAL[3];
            mpie_q     <= MSTATUS_RESETVAL[7];
            mtie_q     <= 1'b0;
            mtip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESETVAL;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
`ifdef ysyx_22050598_CSR_COUNTERS_EN
            mcycle_q   <= '0;
            minstret_q <= '0;
`endif
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtie_q     <= mtie_d;
            mtip_q     <= mtip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
`ifdef ysyx_22050598_CSR_COUNTERS_EN
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
`endif
        end
    end

    // Outputs: suppressed or illegal accesses return zero; only vectored interrupts add the offset.
    always_comb begin
        bus.redirect_o    = irq_take | ecall_take | mret_take;
        bus.illegal_csr_o = illegal;
        bus.csr_rdata_o   = (csr_exec & ~illegal) ? rd_val : '0;
        bus.redirect_pc_o = '0;
        if (irq_take)
            bus.redirect_pc_o = (mtvec_q[1:0] == 2'b01) ? trap_base + XLEN'(28) : trap_base;
        else if (ecall_take)
            bus.redirect_pc_o = trap_base;
        else if (mret_take)
            bus.redirect_pc_o = mepc_q;
    end
endmodule
